// File: rtl/status_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : status_uart_tx
//  Purpose  : Serializes 24-bit status words as 4-byte 8N1 UART frames
//             (HEADER, data[23:16], data[15:8], data[7:0], LSB first).
//             A single pending register holds the newest unsent word; a
//             newer write overwrites it and pulses overrun.
//  Ports    : clk      - system clock, rising edge
//             rst      - asynchronous active-high reset
//             in_data  - status word, sampled when in_wr=1
//             in_wr    - write strobe, every high cycle is a write
//             tx       - UART line, idle high, flop-driven
//             busy     - frame in progress or word pending
//             overrun  - one-cycle pulse when a pending word is overwritten
//  Revision : 1.0 - initial release
// ============================================================================
module status_uart_tx #(
  parameter int         CLK_DIV = 434,
  parameter logic [7:0] HEADER  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_data,
  input  logic        in_wr,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      shreg_q, shreg_d;
  logic [23:0]      pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             consume;
  logic             cnt_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      shreg_q    <= '0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      shreg_q    <= shreg_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shreg_d    = shreg_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    overrun_d  = 1'b0;
    tx_d       = 1'b1;
    consume    = (state_q == IDLE) && pend_v_q;
    cnt_wrap   = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (pend_v_q) begin
          // Bytes are stored low-end first so the whole frame shifts out
          // LSB-first from bit 0: HEADER, then data[23:16], [15:8], [7:0].
          shreg_d    = {pend_q[7:0], pend_q[15:8], pend_q[23:16], HEADER};
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          cnt_d      = '0;
          state_d    = START;
        end
      end
      START: begin
        if (cnt_wrap) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (byte_idx_q != 2'd3) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A write in the consume cycle wins: the frame takes the old word and
    // the new one stays pending without counting as an overrun.
    if (consume) begin
      pend_v_d = 1'b0;
    end
    if (in_wr) begin
      pend_d    = in_data;
      pend_v_d  = 1'b1;
      overrun_d = pend_v_q && !consume;
    end

    // Outputs are computed from next-state values so the flops present
    // the line level and busy flag of the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || pend_v_d;
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_status_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_uart_tx
//  Purpose  : Self-checking bench for status_uart_tx. Three instances
//             (CLK_DIV 4/A5, 2/5A, 7/5A) are compared cycle by cycle against
//             waveforms built from the UART frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_status_uart_tx;

  logic        clk;
  logic        rst;
  logic [23:0] in_data;
  logic [2:0]  in_wr;
  wire  [2:0]  tx_w;
  wire  [2:0]  busy_w;
  wire  [2:0]  ovr_w;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ovr_cnt  [3];
  int ovr_last [3];

  status_uart_tx #(.CLK_DIV(4), .HEADER(8'hA5)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0])
  );
  status_uart_tx #(.CLK_DIV(2), .HEADER(8'h5A)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1])
  );
  status_uart_tx #(.CLK_DIV(7), .HEADER(8'h5A)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 3; i++) begin
      ovr_cnt[i]  = 0;
      ovr_last[i] = -1;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ovr_w[i] === 1'b1) begin
        ovr_cnt[i]  = ovr_cnt[i] + 1;
        ovr_last[i] = cyc;
      end
    end
  end

  // Expected tx level for each cycle of one frame: 4 bytes of
  // {start 0, 8 data bits LSB first, stop 1}, each bit lasting cd cycles.
  function automatic logic [279:0] exp_wave(input logic [7:0] hdr,
                                            input logic [23:0] w,
                                            input int cd);
    logic [7:0]   b [4];
    logic [279:0] r;
    b[0] = hdr;
    b[1] = w[23:16];
    b[2] = w[15:8];
    b[3] = w[7:0];
    r = '0;
    for (int k = 0; k < 40 * cd; k++) begin
      int p;
      int bi;
      int pos;
      p   = k / cd;
      bi  = p / 10;
      pos = p % 10;
      if (pos == 0)      r[k] = 1'b0;
      else if (pos == 9) r[k] = 1'b1;
      else               r[k] = b[bi][pos-1];
    end
    return r;
  endfunction

  // Called at a negedge; drives one write cycle and returns at the next negedge.
  task automatic do_write(input int idx, input logic [23:0] d, output int wc);
    wc         = cyc;
    in_data    = d;
    in_wr[idx] = 1'b1;
    @(negedge clk);
    in_wr[idx] = 1'b0;
  endtask

  // Waits for the start-bit fall, then records one frame's worth of samples.
  task automatic capture(input int idx, input int cd, input int budget,
                         output int fall, output logic [279:0] wave);
    int t;
    t    = 0;
    wave = '0;
    fall = -1;
    do begin
      @(negedge clk);
      t++;
    end while (tx_w[idx] !== 1'b0 && t < budget);
    if (tx_w[idx] !== 1'b0) return;
    fall = cyc;
    for (int k = 0; k < 40 * cd; k++) begin
      if (k > 0) @(negedge clk);
      wave[k] = tx_w[idx];
    end
  endtask

  // Counts cycles in which any instance is not idle.
  task automatic quiet_cycles(input int n, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx_w !== 3'b111 || busy_w !== 3'b000) bad++;
    end
  endtask

  task automatic test_reset();
    int w;
    int bad;
    rst     = 1'b1;
    in_wr   = 3'b000;
    in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_write(0, 24'($urandom), w);
    repeat (10) @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy: got %b want 1", busy_w[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_w !== 3'b111) begin
      failures++;
      $display("FAIL reset_async_tx: got %b want 111", tx_w);
    end
    checks++;
    if (busy_w !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_busy: got %b want 000", busy_w);
    end
    checks++;
    if (ovr_w !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_overrun: got %b want 000", ovr_w);
    end
    @(negedge clk);
    rst = 1'b0;
    quiet_cycles(1000, bad);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_single();
    int w;
    int f;
    int o0;
    logic [279:0] wv;
    logic [279:0] ex;
    o0 = ovr_cnt[0];
    ex = exp_wave(8'hA5, 24'h123456, 4);
    do_write(0, 24'h123456, w);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_pending: got %b want 1", busy_w[0]);
    end
    capture(0, 4, 20, f, wv);
    checks++;
    if (f != w + 2) begin
      failures++;
      $display("FAIL single_latency: got fall %0d want %0d", f, w + 2);
    end
    checks++;
    if (wv !== ex) begin
      failures++;
      $display("FAIL single_wave: got %h want %h", wv[159:0], ex[159:0]);
    end
    @(negedge clk);
    checks++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_end: got busy %b tx %b want busy 0 tx 1", busy_w[0], tx_w[0]);
    end
    checks++;
    if (ovr_cnt[0] != o0) begin
      failures++;
      $display("FAIL single_overrun: got %0d pulses want 0", ovr_cnt[0] - o0);
    end
  endtask

  task automatic test_overrun();
    int w;
    int t;
    int f1;
    int f2;
    int o0;
    logic [279:0] wv1;
    logic [279:0] wv2;
    o0 = ovr_cnt[0];
    w  = cyc;
    in_data  = 24'h000001;
    in_wr[0] = 1'b1;
    fork
      begin
        @(negedge clk);
        in_wr[0] = 1'b0;
        while (cyc != w + 22) @(negedge clk);
        do_write(0, 24'h000002, t);
        while (cyc != w + 32) @(negedge clk);
        do_write(0, 24'h000003, t);
      end
      begin
        capture(0, 4, 20, f1, wv1);
        capture(0, 4, 20, f2, wv2);
      end
    join
    @(negedge clk);
    checks++;
    if (f1 != w + 2) begin
      failures++;
      $display("FAIL ovr_latency: got fall %0d want %0d", f1, w + 2);
    end
    checks++;
    if (wv1 !== exp_wave(8'hA5, 24'h000001, 4)) begin
      failures++;
      $display("FAIL ovr_frame1: got %h", wv1[159:0]);
    end
    checks++;
    if (f2 != f1 + 161) begin
      failures++;
      $display("FAIL ovr_gap: got fall %0d want %0d", f2, f1 + 161);
    end
    checks++;
    if (wv2 !== exp_wave(8'hA5, 24'h000003, 4)) begin
      failures++;
      $display("FAIL ovr_frame2: got %h", wv2[159:0]);
    end
    checks++;
    if (ovr_cnt[0] - o0 != 1) begin
      failures++;
      $display("FAIL ovr_count: got %0d pulses want 1", ovr_cnt[0] - o0);
    end
    checks++;
    if (ovr_last[0] != w + 33) begin
      failures++;
      $display("FAIL ovr_when: got cycle %0d want %0d", ovr_last[0], w + 33);
    end
    checks++;
    if (busy_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL ovr_busy_end: got %b want 0", busy_w[0]);
    end
  endtask

  task automatic test_collision();
    int w;
    int t;
    int f0;
    int f1;
    int f2;
    int o0;
    logic [23:0]  r0;
    logic [279:0] wv0;
    logic [279:0] wv1;
    logic [279:0] wv2;
    o0 = ovr_cnt[0];
    r0 = 24'($urandom);
    w  = cyc;
    in_data  = r0;
    in_wr[0] = 1'b1;
    fork
      begin
        @(negedge clk);
        in_wr[0] = 1'b0;
        while (cyc != w + 50) @(negedge clk);
        do_write(0, 24'hAAAAAA, t);
        // The single IDLE cycle between frames is the consume cycle.
        while (cyc != w + 162) @(negedge clk);
        do_write(0, 24'hBBBBBB, t);
      end
      begin
        capture(0, 4, 20, f0, wv0);
        capture(0, 4, 20, f1, wv1);
        capture(0, 4, 20, f2, wv2);
      end
    join
    @(negedge clk);
    checks++;
    if (wv0 !== exp_wave(8'hA5, r0, 4) || f0 != w + 2) begin
      failures++;
      $display("FAIL coll_frame0: got fall %0d want %0d wave %h", f0, w + 2, wv0[159:0]);
    end
    checks++;
    if (f1 != f0 + 161 || wv1 !== exp_wave(8'hA5, 24'hAAAAAA, 4)) begin
      failures++;
      $display("FAIL coll_frame1: got fall %0d want %0d wave %h", f1, f0 + 161, wv1[159:0]);
    end
    checks++;
    if (f2 != f1 + 161 || wv2 !== exp_wave(8'hA5, 24'hBBBBBB, 4)) begin
      failures++;
      $display("FAIL coll_frame2: got fall %0d want %0d wave %h", f2, f1 + 161, wv2[159:0]);
    end
    checks++;
    if (ovr_cnt[0] != o0) begin
      failures++;
      $display("FAIL coll_overrun: got %0d pulses want 0", ovr_cnt[0] - o0);
    end
  endtask

  task automatic test_level_hold();
    int w;
    int f0;
    int f1;
    int o0;
    logic [23:0]  r0;
    logic [23:0]  d [5];
    logic [279:0] wv0;
    logic [279:0] wv1;
    o0 = ovr_cnt[0];
    r0 = 24'($urandom);
    w  = cyc;
    in_data  = r0;
    in_wr[0] = 1'b1;
    fork
      begin
        @(negedge clk);
        in_wr[0] = 1'b0;
        while (cyc != w + 40) @(negedge clk);
        in_wr[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
          d[i]    = 24'($urandom);
          in_data = d[i];
          @(negedge clk);
        end
        in_wr[0] = 1'b0;
      end
      begin
        capture(0, 4, 20, f0, wv0);
        capture(0, 4, 20, f1, wv1);
      end
    join
    @(negedge clk);
    checks++;
    if (wv0 !== exp_wave(8'hA5, r0, 4)) begin
      failures++;
      $display("FAIL hold_frame0: got %h", wv0[159:0]);
    end
    checks++;
    if (f1 != f0 + 161 || wv1 !== exp_wave(8'hA5, d[4], 4)) begin
      failures++;
      $display("FAIL hold_frame1: got fall %0d want %0d wave %h", f1, f0 + 161, wv1[159:0]);
    end
    checks++;
    if (ovr_cnt[0] - o0 != 4) begin
      failures++;
      $display("FAIL hold_overrun: got %0d pulses want 4", ovr_cnt[0] - o0);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int t;
    int bad;
    logic [279:0] ex;
    ex = exp_wave(8'hA5, 24'h123456, 4);
    do_write(0, 24'h123456, w);
    while (cyc != w + 30) @(negedge clk);
    do_write(0, 24'($urandom), t);
    // Frame cycle 97: byte 2, data bit 3.
    while (cyc != w + 2 + 97) @(negedge clk);
    checks++;
    if (tx_w[0] !== ex[97] || busy_w[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pre: got tx %b busy %b want tx %b busy 1", tx_w[0], busy_w[0], ex[97]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || ovr_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL mid_async: got tx %b busy %b ovr %b want 1 0 0", tx_w[0], busy_w[0], ovr_w[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_cycles(1000, bad);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mid_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_sweep();
    int w;
    int f;
    int cd;
    logic [279:0] wv;
    for (int idx = 1; idx < 3; idx++) begin
      cd = (idx == 1) ? 2 : 7;
      do_write(idx, 24'hFF00FF, w);
      capture(idx, cd, 20, f, wv);
      checks++;
      if (f != w + 2) begin
        failures++;
        $display("FAIL sweep_latency_%0d: got fall %0d want %0d", cd, f, w + 2);
      end
      checks++;
      if (wv !== exp_wave(8'h5A, 24'hFF00FF, cd)) begin
        failures++;
        $display("FAIL sweep_wave_%0d: got %h want %h", cd, wv, exp_wave(8'h5A, 24'hFF00FF, cd));
      end
      @(negedge clk);
      checks++;
      if (busy_w[idx] !== 1'b0) begin
        failures++;
        $display("FAIL sweep_busy_%0d: got %b want 0", cd, busy_w[idx]);
      end
    end
  endtask

  task automatic test_random();
    int w;
    int f;
    int cd;
    logic [7:0]   hdr;
    logic [23:0]  r;
    logic [279:0] wv;
    for (int idx = 0; idx < 3; idx++) begin
      cd  = (idx == 0) ? 4 : ((idx == 1) ? 2 : 7);
      hdr = (idx == 0) ? 8'hA5 : 8'h5A;
      for (int n = 0; n < 3; n++) begin
        r = 24'($urandom);
        do_write(idx, r, w);
        capture(idx, cd, 20, f, wv);
        checks++;
        if (f != w + 2 || wv !== exp_wave(hdr, r, cd)) begin
          failures++;
          $display("FAIL random_%0d_%0d: got fall %0d want %0d data %h wave %h", idx, n, f, w + 2, r, wv);
        end
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_collision();
    test_level_hold();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
